// File: rtl/rain_wiper_pkg.sv
// rain_wiper_pkg: shared types, speed encodings and popcount helper for the
// rain-sensing wiper controller.
package rain_wiper_pkg;

  localparam logic [1:0] SPEED_OFF  = 2'b00;
  localparam logic [1:0] SPEED_SLOW = 2'b01;
  localparam logic [1:0] SPEED_FAST = 2'b10;

  typedef enum logic [1:0] {
    W_OFF  = SPEED_OFF,
    W_SLOW = SPEED_SLOW,
    W_FAST = SPEED_FAST
  } wiper_speed_t;

  // Widest sensor vector the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX_W = 32;

  // Counts set bits in the low 'width' bits of vec.
  function automatic int popcount(input logic [POP_MAX_W-1:0] vec, input int width);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < width && vec[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rain_wiper_ctrl_if.sv
// rain_wiper_ctrl_if: sensor input and LED/motor output bundle of the wiper
// controller. The controller uses the slave modport, the board side the master.
interface rain_wiper_ctrl_if
  import rain_wiper_pkg::*;
#(
  parameter int NSENS = 7
);
  localparam int LVL_W = $clog2(NSENS + 1);

  logic [NSENS-1:0] drops;
  wiper_speed_t     speed;
  logic [LVL_W-1:0] level;
  logic             tick;
  logic             sweep;

  modport master (output drops, input speed, input level, input tick, input sweep);
  modport slave  (input drops, output speed, output level, output tick, output sweep);
endinterface

// File: rtl/rain_wiper_sweep.sv
// rain_wiper_sweep: periodic one-cycle wipe pulse generator. Counts sample
// ticks while the wiper runs; a speed change reloads the counter so the first
// sweep of a new speed fires on the next tick.
module rain_wiper_sweep
  import rain_wiper_pkg::*;
#(
  parameter int SLOW_PERIOD = 8,
  parameter int FAST_PERIOD = 3
) (
  input  logic         clk_2,
  input  logic         reset_n,
  input  logic         tick,
  input  wiper_speed_t speed,
  output logic         sweep
);

  localparam int MAXPER = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
  localparam int CW     = (MAXPER > 1) ? $clog2(MAXPER) : 1;
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_PERIOD - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_PERIOD - 1);

  if (SLOW_PERIOD < 1 || FAST_PERIOD < 1) begin : g_bad_period
    $error("rain_wiper_sweep: periods must be >= 1");
  end

  wiper_speed_t  spd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] per_last;
  logic [CW-1:0] cnt_eff;

  // Effective count: a freshly changed speed behaves as if the counter sat at its last value.
  always_comb begin
    per_last = (speed == W_FAST) ? FAST_LAST : SLOW_LAST;
    cnt_eff  = (speed != spd_q) ? per_last : cnt_q;
  end

  // Tick counter, speed tracker and registered sweep pulse.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      spd_q <= W_OFF;
      cnt_q <= '0;
      sweep <= 1'b0;
    end else begin
      spd_q <= speed;
      sweep <= 1'b0;
      if (speed == W_OFF) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_eff == per_last) begin
          sweep <= 1'b1;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_eff + CW'(1);
        end
      end else begin
        cnt_q <= cnt_eff;
      end
    end
  end

endmodule

// File: rtl/rain_wiper_ctrl.sv
// rain_wiper_ctrl: rain-sensing wiper controller. Samples the drop sensors on
// a prescaled tick, qualifies the drop count with persistence/hysteresis and
// selects OFF/SLOW/FAST.
// Build macro RAIN_WIPER_SWEEP_EN: when defined, the sweep pulse generator is
// instantiated; otherwise sweep is tied low and the periods are only checked.
//
// state  | meaning
// W_OFF  | wiper parked, no sweeps
// W_SLOW | light rain, sweep every SLOW_PERIOD ticks
// W_FAST | heavy rain, sweep every FAST_PERIOD ticks
module rain_wiper_ctrl
  import rain_wiper_pkg::*;
#(
  parameter int NSENS        = 7,
  parameter int PRESC_DIV    = 2,
  parameter int SLOW_ON      = 3,
  parameter int SLOW_OFF     = 2,
  parameter int FAST_ON      = 5,
  parameter int FAST_OFF     = 4,
  parameter int SLOW_PERSIST = 3,
  parameter int FAST_PERSIST = 2,
  parameter int DOWN_PERSIST = 2,
  parameter int SLOW_PERIOD  = 8,
  parameter int FAST_PERIOD  = 3
) (
  input logic              clk_2,
  input logic              reset_n,
  rain_wiper_ctrl_if.slave bus
);

  localparam int LVL_W = $clog2(NSENS + 1);
  localparam int PS_W  = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC_DIV - 1);
  localparam int MAXP1 = (SLOW_PERSIST > FAST_PERSIST) ? SLOW_PERSIST : FAST_PERSIST;
  localparam int MAXP  = (MAXP1 > DOWN_PERSIST) ? MAXP1 : DOWN_PERSIST;
  localparam int CW    = $clog2(MAXP + 1);
  localparam logic [CW-1:0] SP_V = CW'(SLOW_PERSIST);
  localparam logic [CW-1:0] FP_V = CW'(FAST_PERSIST);
  localparam logic [CW-1:0] DP_V = CW'(DOWN_PERSIST);

  if (!(SLOW_OFF <= SLOW_ON && SLOW_ON <= FAST_ON &&
        SLOW_OFF <= FAST_OFF && FAST_OFF <= FAST_ON)) begin : g_bad_thresh
    $error("rain_wiper_ctrl: illegal threshold ordering");
  end
  if (SLOW_PERSIST < 1 || FAST_PERSIST < 1 || DOWN_PERSIST < 1) begin : g_bad_persist
    $error("rain_wiper_ctrl: persistence counts must be >= 1");
  end
  if (SLOW_PERIOD < 1 || FAST_PERIOD < 1 || PRESC_DIV < 1) begin : g_bad_period
    $error("rain_wiper_ctrl: periods and prescaler must be >= 1");
  end
  if (NSENS < 1 || NSENS > POP_MAX_W) begin : g_bad_nsens
    $error("rain_wiper_ctrl: NSENS out of range");
  end

  logic [PS_W-1:0]  ps_q;
  logic             tick;
  logic [LVL_W-1:0] pc;
  logic [LVL_W-1:0] level_q;
  wiper_speed_t     state_q;
  wiper_speed_t     state_d;
  logic [CW-1:0]    c_slow_q, c_fast_q, c_off_q, c_down_q;
  logic [CW-1:0]    n_slow, n_fast, n_off, n_down;
  logic             fire_slow, fire_fast, fire_off, fire_down;
  logic             sweep_w;

  assign tick = (ps_q == PS_LAST);

  // Sample prescaler: wraps after PRESC_DIV cycles.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) ps_q <= '0;
    else if (tick) ps_q <= '0;
    else           ps_q <= ps_q + PS_W'(1);
  end

  // Drop count and the saturating persistence counters' candidate values.
  always_comb begin
    pc = LVL_W'(popcount(POP_MAX_W'(bus.drops), NSENS));
    n_slow = (int'(pc) >= SLOW_ON) ? ((c_slow_q == SP_V) ? SP_V : c_slow_q + CW'(1)) : '0;
    n_fast = (int'(pc) >= FAST_ON) ? ((c_fast_q == FP_V) ? FP_V : c_fast_q + CW'(1)) : '0;
    n_off  = (int'(pc) <  SLOW_OFF) ? ((c_off_q == DP_V) ? DP_V : c_off_q + CW'(1)) : '0;
    n_down = (int'(pc) <  FAST_OFF) ? ((c_down_q == DP_V) ? DP_V : c_down_q + CW'(1)) : '0;
    fire_slow = (n_slow == SP_V);
    fire_fast = (n_fast == FP_V);
    fire_off  = (n_off  == DP_V);
    fire_down = (n_down == DP_V);
  end

  // Next-state logic; transitions only on a sample tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        W_OFF: begin
          if (fire_fast)      state_d = W_FAST;
          else if (fire_slow) state_d = W_SLOW;
        end
        W_SLOW: begin
          if (fire_fast)     state_d = W_FAST;
          else if (fire_off) state_d = W_OFF;
        end
        W_FAST: begin
          if (fire_off)       state_d = W_OFF;
          else if (fire_down) state_d = W_SLOW;
        end
        default: state_d = W_OFF;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) state_q <= W_OFF;
    else          state_q <= state_d;
  end

  // Latched level and persistence counters; any state change restarts qualification.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= '0;
      c_slow_q <= '0;
      c_fast_q <= '0;
      c_off_q  <= '0;
      c_down_q <= '0;
    end else if (tick) begin
      level_q <= pc;
      if (state_d != state_q) begin
        c_slow_q <= '0;
        c_fast_q <= '0;
        c_off_q  <= '0;
        c_down_q <= '0;
      end else begin
        c_slow_q <= n_slow;
        c_fast_q <= n_fast;
        c_off_q  <= n_off;
        c_down_q <= n_down;
      end
    end
  end

`ifdef RAIN_WIPER_SWEEP_EN
  rain_wiper_sweep #(
    .SLOW_PERIOD(SLOW_PERIOD),
    .FAST_PERIOD(FAST_PERIOD)
  ) u_sweep (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .tick   (tick),
    .speed  (state_q),
    .sweep  (sweep_w)
  );
`else
  assign sweep_w = 1'b0;
`endif

  // Output drive.
  always_comb begin
    bus.speed = state_q;
    bus.level = level_q;
    bus.tick  = tick;
    bus.sweep = sweep_w;
  end

endmodule

// File: tb/tb_rain_wiper_ctrl.sv
// tb_rain_wiper_ctrl: directed scenarios plus randomized drop patterns, checked
// every cycle against a tick-level behavioural model of the controller.
module tb_rain_wiper_ctrl;
  import rain_wiper_pkg::*;

  localparam int NSENS = 7, PRESC_DIV = 2;
  localparam int SLOW_ON = 3, SLOW_OFF = 2, FAST_ON = 5, FAST_OFF = 4;
  localparam int SLOW_PERSIST = 3, FAST_PERSIST = 2, DOWN_PERSIST = 2;
  localparam int SLOW_PERIOD = 8, FAST_PERIOD = 3;

  logic clk_2 = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  rain_wiper_ctrl_if #(.NSENS(NSENS)) bus ();

  rain_wiper_ctrl #(
    .NSENS(NSENS), .PRESC_DIV(PRESC_DIV),
    .SLOW_ON(SLOW_ON), .SLOW_OFF(SLOW_OFF), .FAST_ON(FAST_ON), .FAST_OFF(FAST_OFF),
    .SLOW_PERSIST(SLOW_PERSIST), .FAST_PERSIST(FAST_PERSIST), .DOWN_PERSIST(DOWN_PERSIST),
    .SLOW_PERIOD(SLOW_PERIOD), .FAST_PERIOD(FAST_PERIOD)
  ) dut (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (per-tick rules) ----------------
  int m_ps = 0, m_speed = 0, m_level = 0, m_n = 0;
  bit m_sweep = 0;
  int hist[$];

  function automatic bit meets(int pc, int kind);
    case (kind)
      0: return pc >= SLOW_ON;
      1: return pc >= FAST_ON;
      2: return pc < SLOW_OFF;
      default: return pc < FAST_OFF;
    endcase
  endfunction

  // True when the last p samples since the last speed change all satisfy 'kind'.
  function automatic bit last_n(int p, int kind);
    if (hist.size() < p) return 0;
    for (int i = hist.size() - p; i < hist.size(); i++)
      if (!meets(hist[i], kind)) return 0;
    return 1;
  endfunction

  function automatic int decide(int cur);
    case (cur)
      0: return last_n(FAST_PERSIST, 1) ? 2 : (last_n(SLOW_PERSIST, 0) ? 1 : 0);
      1: return last_n(FAST_PERSIST, 1) ? 2 : (last_n(DOWN_PERSIST, 2) ? 0 : 1);
      default: return last_n(DOWN_PERSIST, 2) ? 0 : (last_n(DOWN_PERSIST, 3) ? 1 : 2);
    endcase
  endfunction

  always @(posedge clk_2 or negedge reset_n) begin
    int pc, nxt;
    if (!reset_n) begin
      m_ps = 0; m_speed = 0; m_level = 0; m_sweep = 0; m_n = 0;
      hist.delete();
    end else begin
      m_sweep = 0;
      if (m_ps == PRESC_DIV - 1) begin
        m_ps = 0;
        pc = $countones(bus.drops);
        m_level = pc;
        if (m_speed != 0) begin
          m_n++;
          if ((m_n - 1) % ((m_speed == 1) ? SLOW_PERIOD : FAST_PERIOD) == 0) m_sweep = 1;
        end
        hist.push_back(pc);
        if (hist.size() > 16) void'(hist.pop_front());
        nxt = decide(m_speed);
        if (nxt != m_speed) begin
          m_speed = nxt;
          m_n = 0;
          hist.delete();
        end
      end else begin
        m_ps++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_2) begin
    if (cmp_en) begin
      check("speed", 32'(bus.speed), 32'(m_speed));
      check("level", 32'(bus.level), 32'(m_level));
      check("tick", 32'(bus.tick), 32'(m_ps == PRESC_DIV - 1));
`ifdef RAIN_WIPER_SWEEP_EN
      check("sweep", 32'(bus.sweep), 32'(m_sweep));
`else
      check("sweep", 32'(bus.sweep), 32'd0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [NSENS-1:0] rand_vec(int k);
    logic [NSENS-1:0] v;
    v = '0;
    while ($countones(v) < k) v[$urandom_range(0, NSENS - 1)] = 1'b1;
    return v;
  endfunction

  // Presents a pattern with k wet cells for one full tick period; ends just after the tick edge.
  task automatic do_tick(input int k);
    bus.drops = rand_vec(k);
    repeat (PRESC_DIV) @(posedge clk_2);
    @(negedge clk_2);
  endtask

  // Async reset between edges, checked immediately, released on a falling edge.
  task automatic apply_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_speed", 32'(bus.speed), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_sweep", 32'(bus.sweep), 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_sp[$];
    int cnts[$];
    bus.drops = '0;
    repeat (3) @(negedge clk_2);
    reset_n = 1'b1;
    cmp_en = 1;

    // Slow entry: 3 drops held -> SLOW on third tick, sweeps on tick 4 and 12.
    for (int i = 1; i <= 12; i++) begin
      do_tick(3);
      if (i <= 3) check("slow_entry_speed", 32'(bus.speed), (i == 3) ? 32'd1 : 32'd0);
`ifdef RAIN_WIPER_SWEEP_EN
      if (i >= 4) check("slow_sweep", 32'(bus.sweep), (i == 4 || i == 12) ? 32'd1 : 32'd0);
`else
      if (i >= 4) check("slow_sweep_off", 32'(bus.sweep), 32'd0);
`endif
    end

    // Persistence restart: 3,3,1,3,3,3.
    apply_reset();
    cnts = '{3, 3, 1, 3, 3, 3};
    exp_sp = '{0, 0, 0, 0, 0, 1};
    foreach (cnts[i]) begin
      do_tick(cnts[i]);
      check("persist_speed", 32'(bus.speed), 32'(exp_sp[i]));
    end

    // Fast entry and hysteresis.
    apply_reset();
    cnts = '{5, 5, 4, 4, 4, 3, 3, 1, 1};
    exp_sp = '{0, 2, 2, 2, 2, 2, 1, 1, 0};
    foreach (cnts[i]) begin
      do_tick(cnts[i]);
      check("hyst_speed", 32'(bus.speed), 32'(exp_sp[i]));
      check("hyst_level", 32'(bus.level), 32'(cnts[i]));
    end

    // Priority: FAST straight to OFF, then OFF straight to FAST.
    apply_reset();
    cnts = '{5, 5, 1, 1, 6, 6};
    exp_sp = '{0, 2, 2, 0, 0, 2};
    foreach (cnts[i]) begin
      do_tick(cnts[i]);
      check("prio_speed", 32'(bus.speed), 32'(exp_sp[i]));
    end

    // Reset mid-sweep with all cells wet, then first tick two cycles after release.
    repeat (4) do_tick(7);
    @(posedge clk_2);
    apply_reset();
    @(posedge clk_2); #1;
    check("post_rst_tick", 32'(bus.tick), 32'd1);
    check("post_rst_level0", 32'(bus.level), 32'd0);
    @(posedge clk_2); #1;
    check("post_rst_level", 32'(bus.level), 32'd7);
    @(negedge clk_2);

    // Randomized drop runs with occasional async resets.
    for (int r = 0; r < 400; r++) begin
      int k, len;
      k = $urandom_range(0, NSENS);
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        bus.drops = rand_vec(k);
        @(negedge clk_2);
      end
      if ($urandom_range(0, 40) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk_2);
        reset_n = 1'b1;
      end
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
